// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID latch, stall/branch handling
// and saturating fetch/stall counters.
package fetch_pkg;
    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;
endpackage

module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] ifid_instruction,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic [15:0] fetch_count,
    output logic [15:0] stall_count
);

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    if_id_t      ifid;
    if_id_t      ifid_next;
    logic        fetch_inc;
    logic        stall_inc;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    always_comb begin
        pc_next   = pc;
        ifid_next = ifid;
        fetch_inc = 1'b0;
        stall_inc = 1'b0;
        priority case (1'b1)
            branch_taken: begin
                pc_next = {branch_target[31:2], 2'b00};
                if (DELAY_SLOT) begin
                    ifid_next = '{imem_data, pc_plus4, 1'b1};
                    fetch_inc = 1'b1;
                end else begin
                    ifid_next = '{32'h0, 32'h0, 1'b0};
                end
            end
            stall: begin
                stall_inc = 1'b1;
            end
            default: begin
                pc_next   = pc_plus4;
                ifid_next = '{imem_data, pc_plus4, 1'b1};
                fetch_inc = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc   <= PC_INIT;
            ifid <= '{32'h0, 32'h0, 1'b0};
        end else begin
            pc   <= pc_next;
            ifid <= ifid_next;
        end
    end

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count <= 16'h0;
            stall_count <= 16'h0;
        end else begin
            if (fetch_inc && fetch_count != 16'hFFFF)
                fetch_count <= fetch_count + 16'd1;
            if (stall_inc && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end

    assign ifid_instruction = ifid.instruction;
    assign ifid_pc_plus4    = ifid.pc_plus4;
    assign ifid_valid       = ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench: two fetch_stage instances, DELAY_SLOT=0 (u0)
// and DELAY_SLOT=1 (u1), sharing clock, reset and branch inputs.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall0, stall1;
    logic        branch_taken;
    logic [31:0] branch_target;

    logic [31:0] addr0, addr1, data0, data1;
    logic [31:0] ins0, ins1, pc4_0, pc4_1;
    logic        val0, val1;
    logic [15:0] fc0, fc1, sc0, sc1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a == 32'h200) ? 32'h0 : (a | 32'hE000_0000);
    endfunction

    assign data0 = rom(addr0);
    assign data1 = rom(addr1);

    fetch_stage #(.RESET_PC(32'h0), .DELAY_SLOT(1'b0)) u0 (
        .clk(clk), .reset_n(reset_n), .stall(stall0),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(addr0), .imem_data(data0),
        .ifid_instruction(ins0), .ifid_pc_plus4(pc4_0),
        .ifid_valid(val0), .fetch_count(fc0), .stall_count(sc0)
    );

    fetch_stage #(.RESET_PC(32'h0), .DELAY_SLOT(1'b1)) u1 (
        .clk(clk), .reset_n(reset_n), .stall(stall1),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(addr1), .imem_data(data1),
        .ifid_instruction(ins1), .ifid_pc_plus4(pc4_1),
        .ifid_valid(val1), .fetch_count(fc1), .stall_count(sc1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " addr0"}, addr0, 32'h0);
        chk({tag, " ins0"}, ins0, 32'h0);
        chk({tag, " pc4_0"}, pc4_0, 32'h0);
        chk({tag, " val0"}, {31'h0, val0}, 32'h0);
        chk({tag, " fc0"}, {16'h0, fc0}, 32'h0);
        chk({tag, " sc0"}, {16'h0, sc0}, 32'h0);
        chk({tag, " addr1"}, addr1, 32'h0);
        chk({tag, " ins1"}, ins1, 32'h0);
        chk({tag, " val1"}, {31'h0, val1}, 32'h0);
        chk({tag, " fc1"}, {16'h0, fc1}, 32'h0);
        chk({tag, " sc1"}, {16'h0, sc1}, 32'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        stall0 = 1'b0;
        stall1 = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;

        tick(3);
        chk_zero("reset");
        reset_n = 1'b1;

        tick(3);
        chk("seq ins", ins0, 32'hE000_0008);
        chk("seq pc4", pc4_0, 32'd12);
        chk("seq fc", {16'h0, fc0}, 32'd3);
        chk("seq val", {31'h0, val0}, 32'd1);
        chk("seq addr", addr0, 32'h0C);

        tick();
        chk("pre-stall addr", addr0, 32'h10);
        stall0 = 1'b1;
        stall1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stall ins", ins0, 32'hE000_000C);
            chk("stall addr", addr0, 32'h10);
        end
        chk("stall cnt", {16'h0, sc0}, 32'd4);
        chk("stall fc", {16'h0, fc0}, 32'd4);
        stall0 = 1'b0;
        stall1 = 1'b0;
        tick();
        chk("resume ins", ins0, 32'hE000_0010);
        chk("resume pc4", pc4_0, 32'h14);
        chk("resume fc", {16'h0, fc0}, 32'd5);

        tick(3);
        chk("at 0x20", addr0, 32'h20);
        chk("fc before br", {16'h0, fc0}, 32'd8);
        branch_taken = 1'b1;
        branch_target = 32'h103;
        tick();
        chk("br0 addr", addr0, 32'h100);
        chk("br0 ins", ins0, 32'h0);
        chk("br0 val", {31'h0, val0}, 32'd0);
        chk("br0 pc4", pc4_0, 32'h0);
        chk("br0 fc", {16'h0, fc0}, 32'd8);
        chk("br1 addr", addr1, 32'h100);
        chk("br1 ins", ins1, 32'hE000_0020);
        chk("br1 val", {31'h0, val1}, 32'd1);
        chk("br1 pc4", pc4_1, 32'h24);
        chk("br1 fc", {16'h0, fc1}, 32'd9);
        branch_taken = 1'b0;
        tick();
        chk("tgt0 ins", ins0, 32'hE000_0100);
        chk("tgt0 pc4", pc4_0, 32'h104);
        chk("tgt0 val", {31'h0, val0}, 32'd1);
        chk("tgt0 fc", {16'h0, fc0}, 32'd9);
        chk("tgt1 ins", ins1, 32'hE000_0100);
        chk("tgt1 fc", {16'h0, fc1}, 32'd10);

        stall0 = 1'b1;
        stall1 = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h40;
        tick();
        chk("sb addr", addr0, 32'h40);
        chk("sb sc", {16'h0, sc0}, 32'd4);
        chk("sb val0", {31'h0, val0}, 32'd0);
        chk("sb ins1", ins1, 32'hE000_0104);
        chk("sb sc1", {16'h0, sc1}, 32'd4);
        stall0 = 1'b0;
        stall1 = 1'b0;

        branch_target = 32'h200;
        tick();
        branch_taken = 1'b0;
        tick();
        chk("zero ins", ins0, 32'h0);
        chk("zero val", {31'h0, val0}, 32'd1);
        chk("zero pc4", pc4_0, 32'h204);

        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFF;
        tick();
        chk("wrap pre", addr0, 32'hFFFF_FFFC);
        branch_taken = 1'b0;
        tick();
        chk("wrap addr", addr0, 32'h0);
        chk("wrap pc4", pc4_0, 32'h0);
        chk("wrap ins", ins0, 32'hFFFF_FFFC);
        chk("wrap val", {31'h0, val0}, 32'd1);

        stall1 = 1'b1;
        tick(65540);
        chk("fc sat", {16'h0, fc0}, 32'hFFFF);
        chk("sc sat", {16'h0, sc1}, 32'hFFFF);
        tick(3);
        chk("fc sat hold", {16'h0, fc0}, 32'hFFFF);
        chk("sc sat hold", {16'h0, sc1}, 32'hFFFF);

        stall0 = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("async");
        tick();
        reset_n = 1'b1;
        stall0 = 1'b0;
        stall1 = 1'b0;
        tick();
        chk("post ins", ins0, 32'hE000_0000);
        chk("post fc", {16'h0, fc0}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register that feeds the instruction decoder / control unit.
- Holds the program counter and drives the instruction-memory address.
- Registers the returned word together with PC+4 into the IF/ID latch.
- Applies hazard stalls and branch redirection.
- Injects the all-zero NOP word, which the decoder treats as a no-operation, whenever a slot is squashed.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- DELAY_SLOT, 1, 1 = the instruction fetched in the branch cycle is kept (ARM-course delay-slot semantics); 0 = it is squashed to NOP.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- stall  input  1  hazard-unit load-enable deassert; freezes PC and IF/ID.
- branch_taken  input  1  branch resolved taken this cycle.
- branch_target  input  32  redirect address; bits [1:0] ignored (treated as 0).
- imem_addr  output  32  combinational copy of PC to instruction memory.
- imem_data  input  32  instruction word for imem_addr, valid in the same cycle.
- ifid_instruction  output  32  registered instruction to decoder.
- ifid_pc_plus4  output  32  registered PC+4 of that instruction.
- ifid_valid  output  1  1 = ifid_instruction is a real fetched instruction; 0 = bubble/NOP.
- fetch_count  output  16  saturating count of valid instructions loaded into IF/ID.
- stall_count  output  16  saturating count of stalled cycles.

## Operation
- Reset (reset_n low, asynchronous): PC=RESET_PC, ifid_instruction=32'h0, ifid_pc_plus4=32'h0, ifid_valid=0, fetch_count=0, stall_count=0. All outputs hold these values while reset is asserted. Release takes effect at the first rising edge with reset_n high.
- imem_addr = PC at all times, with no register.
- Per rising edge, priority is branch_taken > stall > normal:
  - Normal: PC <= PC+4 (mod 2^32). IF/ID <= {imem_data, PC+4}. ifid_valid <= 1.
  - Stall: PC, IF/ID and ifid_valid hold. stall_count increments.
  - Branch: PC <= {branch_target[31:2],2'b00}. This overrides stall, and stall_count does not increment.
    - DELAY_SLOT=1: IF/ID <= {imem_data, PC+4}, ifid_valid <= 1.
    - DELAY_SLOT=0: IF/ID <= {32'h0, 32'h0}, ifid_valid <= 0.
- A fetched word equal to 32'h0 is loaded normally with ifid_valid=1; the decoder handles it as a NOP.
- fetch_count increments on every edge where ifid_valid is written to 1. Both counters stick at 16'hFFFF.
- PC arithmetic is 32-bit unsigned. PC=32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- PC bits [1:0] are always 0.

## Timing
- Fetch-to-decode latency is 1 cycle: the word at imem_addr in cycle n appears on ifid_instruction after edge n+1.
- Branch penalty:
  - DELAY_SLOT=1: 0 bubbles. The instruction after the branch executes, then the target.
  - DELAY_SLOT=0: exactly 1 bubble (ifid_valid=0 for one cycle).
- Stall held for k cycles freezes IF/ID contents for k cycles. Fetch resumes on the first edge with stall low, refetching the same PC with no loss or duplication.
- Simultaneous stall and branch_taken: the branch wins, PC redirects, and the stall is consumed.
- Asynchronous reset mid-stall or mid-branch discards all state immediately. No partial update completes.
- No combinational path from stall or branch inputs to IF/ID outputs; the only combinational output is imem_addr.

## Test plan
- Reset/sequential fetch: hold reset_n=0 for 3 cycles, then release; ROM word at address a = a|32'hE000_0000.
  - During reset: imem_addr=0, ifid_valid=0, all outputs 0.
  - After 3 edges: ifid_instruction=32'hE000_0008, ifid_pc_plus4=12, fetch_count=3.
- Stall: assert stall for 4 cycles while PC=0x10.
  - IF/ID holds the 0x0C word for all 4 cycles and stall_count=4.
  - The next edge loads the 0x10 word with no skip.
- Branch with DELAY_SLOT=0 at PC=0x20, branch_target=0x103.
  - Next cycle: imem_addr=0x100, ifid_instruction=0, ifid_valid=0.
  - Following cycle: the 0x100 word with ifid_pc_plus4=0x104.
- Branch with DELAY_SLOT=1, same stimulus: IF/ID gets the 0x20 word (valid=1), then the 0x100 word. There are no bubbles and fetch_count increments on both edges.
- Simultaneous stall=1 and branch_taken=1, target 0x40: PC becomes 0x40 and stall_count is unchanged.
- Wrap/saturation: force PC to 32'hFFFF_FFFC via branch.
  - Next PC = 0 and ifid_pc_plus4 = 0.
  - Preload counters by running 65 540 cycles: fetch_count=16'hFFFF and stays there.
- Asynchronous reset pulse mid-cycle during a stall: outputs clear before the next clock edge.
